// File: rtl/print_console_pkg.sv
// print_console_pkg: shared register offsets, status bit positions, bus FSM states
// and the STATUS word packing helper for the console device.
package print_console_pkg;
   localparam logic [1:0] REG_TXDATA = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_COUNT  = 2'd2;
   localparam int ST_EMPTY   = 0;
   localparam int ST_FULL    = 1;
   localparam int ST_OCC_LSB = 8;
   typedef enum logic [1:0] {S_IDLE, S_RESP, S_WAIT_SPACE} bus_state_e;
   function automatic logic [31:0] status_word(input logic empty, input logic full, input logic [7:0] occ);
      logic [31:0] w;
      w = '0;
      w[ST_EMPTY] = empty;
      w[ST_FULL] = full;
      w[ST_OCC_LSB +: 8] = occ;
      return w;
   endfunction
endpackage

// File: rtl/print_console_if.sv
// print_console_if: peripheral valid/ready bus between CPU (master) and console (slave).
//   print_valid/instr/addr/wdata/wstrb : request, held by master until print_ready
//   print_rdata/print_ready           : one-cycle completion with read data
interface print_console_if;
   logic        print_valid;
   logic        print_instr;
   logic [31:0] print_addr;
   logic [31:0] print_wdata;
   logic [3:0]  print_wstrb;
   logic [31:0] print_rdata;
   logic        print_ready;
   modport master (output print_valid, print_instr, print_addr, print_wdata, print_wstrb,
                   input  print_rdata, print_ready);
   modport slave  (input  print_valid, print_instr, print_addr, print_wdata, print_wstrb,
                   output print_rdata, print_ready);
endinterface

// File: rtl/print_fifo.sv
// print_fifo: synchronous FIFO with extra-MSB pointers for full/empty detection.
//   clock_i/reset_i : clock, sync active-high reset
//   push_i/data_i   : write (caller only pushes when not full or popping same cycle)
//   pop_i/data_o    : read head (caller only pops when not empty)
//   full_o/empty_o/count_o : status and occupancy
module print_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [AW:0]      count_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0] wr_q, rd_q;
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (push_i) wr_q <= wr_q + 1'b1;
         if (pop_i) rd_q <= rd_q + 1'b1;
      end
   end
   always_ff @(posedge clock_i) begin
      if (push_i) mem_q[wr_q[AW-1:0]] <= data_i;
   end
   assign data_o  = mem_q[rd_q[AW-1:0]];
   assign empty_o = wr_q == rd_q;
   // same slot index but opposite lap bit means the writer is one full lap ahead
   assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign count_o = wr_q - rd_q;
endmodule

// File: rtl/print_console.sv
// print_console: memory-mapped console; stored bytes queue in a TX FIFO and drain
// one per DRAIN_DIV cycles onto char_valid_o/char_data_o (echoed to the sim log).
//   clock_i/reset_i : clock, sync active-high reset
//   bus             : peripheral slave port (TXDATA/STATUS/COUNT registers)
//   char_valid_o    : one-cycle pulse per drained byte
//   char_data_o     : last drained byte
module print_console
   import print_console_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int DRAIN_DIV  = 4
) (
   input  logic           clock_i,
   input  logic           reset_i,
   print_console_if.slave bus,
   output logic           char_valid_o,
   output logic [7:0]     char_data_o
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;
   localparam logic [CW-1:0] DIV_LAST = CW'(DRAIN_DIV - 1);
   bus_state_e state_q, state_d;
   logic [31:0] rdata_q, rdata_d, count_q;
   logic [CW-1:0] div_q, div_d;
   logic char_valid_q;
   logic [7:0] char_data_q, head;
   logic full, empty, drain, accept, push, wr_tx, rd_req;
   logic [AW:0] occ;
   logic unused_bits;
   assign unused_bits = ^{bus.print_addr[31:4], bus.print_addr[1:0], bus.print_wdata[31:8]};
   assign wr_tx  = !bus.print_instr && bus.print_wstrb[0] && bus.print_addr[3:2] == REG_TXDATA;
   assign rd_req = !bus.print_instr && bus.print_wstrb == 4'b0000;
   assign drain  = !empty && div_q == DIV_LAST;
   assign push   = accept && wr_tx;
   assign div_d  = (empty || drain) ? '0 : div_q + 1'b1;
   always_comb begin
      state_d = state_q;
      accept = 1'b0;
      rdata_d = '0;
      case (state_q)
         // a push into a full FIFO is only taken now if a drain frees the slot this cycle
         S_IDLE: if (bus.print_valid) begin
            if (wr_tx && full && !drain) state_d = S_WAIT_SPACE;
            else begin
               accept = 1'b1;
               state_d = S_RESP;
            end
         end
         S_WAIT_SPACE: if (!full) begin
            accept = 1'b1;
            state_d = S_RESP;
         end
         default: state_d = S_IDLE;
      endcase
      if (accept && rd_req)
         rdata_d = bus.print_addr[3:2] == REG_STATUS ? status_word(empty, full, 8'(occ)) :
                   bus.print_addr[3:2] == REG_COUNT  ? count_q : '0;
   end
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         rdata_q <= '0;
         div_q <= '0;
         count_q <= '0;
         char_valid_q <= 1'b0;
         char_data_q <= '0;
      end else begin
         state_q <= state_d;
         rdata_q <= rdata_d;
         div_q <= div_d;
         char_valid_q <= drain;
         if (drain) begin
            char_data_q <= head;
            count_q <= count_q + 32'd1;
         end
      end
   end
`ifndef SYNTHESIS
   always_ff @(posedge clock_i) begin
      if (!reset_i && drain) $write("%c", head);
   end
`endif
   print_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .push_i  (push),
      .data_i  (bus.print_wdata[7:0]),
      .pop_i   (drain),
      .data_o  (head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (occ)
   );
   assign bus.print_ready = state_q == S_RESP;
   assign bus.print_rdata = rdata_q;
   assign char_valid_o = char_valid_q;
   assign char_data_o = char_data_q;
endmodule

// File: tb/tb_print_console.sv
// tb_print_console: table-driven, directed and random checks of print_console against a queue model.
module tb_print_console;
   localparam int DEPTH = 16;
   localparam int DIV = 40;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic char_valid;
   logic [7:0] char_data;
   print_console_if pif();
   print_console #(.FIFO_DEPTH(DEPTH), .DRAIN_DIV(DIV)) dut (
      .clock_i      (clk),
      .reset_i      (rst),
      .bus          (pif),
      .char_valid_o (char_valid),
      .char_data_o  (char_data)
   );
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   bit chk_en = 1'b0;
   logic [7:0] mq[$];
   int m_due = 0;
   logic [31:0] m_cnt = '0;
   logic m_rdy = 1'b0;
   logic [31:0] m_rdata = '0;
   logic m_stall = 1'b0;
   logic m_cv = 1'b0;
   logic [7:0] m_cd = '0;
   logic [7:0] log_ch[$];
   int log_t[$];

   typedef struct {
      logic        ins;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] exp;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference model: FIFO as a queue, drains scheduled by absolute edge number.
   always @(posedge clk) begin
      bit drain, acc, push, wr_tx;
      int sz;
      logic [31:0] rd;
      cyc++;
      if (rst) begin
         mq.delete();
         m_cnt = '0;
         m_rdy = 1'b0;
         m_rdata = '0;
         m_stall = 1'b0;
         m_cv = 1'b0;
         m_cd = '0;
      end else begin
         sz = mq.size();
         drain = sz > 0 && cyc == m_due;
         acc = 1'b0;
         push = 1'b0;
         rd = '0;
         if (!m_rdy && pif.print_valid) begin
            wr_tx = !pif.print_instr && pif.print_wstrb[0] && pif.print_addr[3:2] == 2'd0;
            if (wr_tx) acc = m_stall ? (sz < DEPTH) : (sz < DEPTH || drain);
            else acc = 1'b1;
            m_stall = wr_tx && !acc;
            push = acc && wr_tx;
            if (acc && !pif.print_instr && pif.print_wstrb == 4'h0)
               rd = pif.print_addr[3:2] == 2'd1 ? {16'h0, 8'(sz), 6'h0, sz == DEPTH, sz == 0} :
                    pif.print_addr[3:2] == 2'd2 ? m_cnt : 32'h0;
         end
         m_rdy = acc;
         m_rdata = rd;
         m_cv = drain;
         if (drain) begin
            m_cd = mq.pop_front();
            m_cnt = m_cnt + 32'd1;
         end
         if (push) mq.push_back(pif.print_wdata[7:0]);
         if ((push && sz == 0) || (drain && mq.size() > 0)) m_due = cyc + DIV;
      end
   end

   always @(negedge clk) begin
      if (char_valid === 1'b1) begin
         log_ch.push_back(char_data);
         log_t.push_back(cyc);
      end
      if (chk_en) begin
         check("sb_ready", {31'h0, pif.print_ready}, {31'h0, m_rdy});
         check("sb_rdata", pif.print_rdata, m_rdata);
         check("sb_char_valid", {31'h0, char_valid}, {31'h0, m_cv});
         check("sb_char_data", {24'h0, char_data}, {24'h0, m_cd});
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus(input logic ins, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd, output int lat, output int ae);
      pif.print_valid = 1'b1;
      pif.print_instr = ins;
      pif.print_addr = a;
      pif.print_wdata = d;
      pif.print_wstrb = s;
      lat = 0;
      rd = '0;
      ae = -1;
      while (1) begin
         @(negedge clk);
         if (pif.print_ready === 1'b1) break;
         lat++;
         if (lat > 200) break;
      end
      if (lat > 200) begin
         checks++;
         errors++;
         $display("FAIL bus_timeout: no ready within %0d cycles for addr 0x%08h", lat, a);
      end else begin
         rd = pif.print_rdata;
         ae = cyc;
      end
      @(posedge clk);
      #1;
      pif.print_valid = 1'b0;
   endtask

   task automatic wait_chars(input int n);
      for (int k = 0; k < 5000 && log_ch.size() < n; k++) @(posedge clk);
      if (log_ch.size() < n) begin
         checks++;
         errors++;
         $display("FAIL wait_chars: got %0d chars expected %0d", log_ch.size(), n);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t tbl[12];
      logic [31:0] rd, a, d;
      logic [3:0] s;
      logic ins;
      logic [7:0] msg[3];
      int lat, ae, ae17, lat17, base, npush, r;
      pif.print_valid = 1'b0;
      pif.print_instr = 1'b0;
      pif.print_addr = '0;
      pif.print_wdata = '0;
      pif.print_wstrb = '0;
      tbl[0]  = '{1'b0, 32'h4,  32'h0,      4'h0, 32'h1};
      tbl[1]  = '{1'b0, 32'h8,  32'h0,      4'h0, 32'h0};
      tbl[2]  = '{1'b0, 32'hC,  32'h0,      4'h0, 32'h0};
      tbl[3]  = '{1'b0, 32'h0,  32'h0,      4'h0, 32'h0};
      tbl[4]  = '{1'b0, 32'h4,  32'hFFFF,   4'hF, 32'h0};
      tbl[5]  = '{1'b0, 32'h8,  32'h1234,   4'hF, 32'h0};
      tbl[6]  = '{1'b0, 32'hC,  32'h61,     4'hF, 32'h0};
      tbl[7]  = '{1'b0, 32'h0,  32'h6161,   4'h2, 32'h0};
      tbl[8]  = '{1'b0, 32'h4,  32'h0,      4'h0, 32'h1};
      tbl[9]  = '{1'b1, 32'h4,  32'h0,      4'h0, 32'h0};
      tbl[10] = '{1'b0, 32'h14, 32'h0,      4'h0, 32'h1};
      tbl[11] = '{1'b0, 32'hF8, 32'h0,      4'h0, 32'h0};
      rst = 1'b1;
      idle(3);
      rst = 1'b0;
      chk_en = 1'b1;
      check("rst_ready", {31'h0, pif.print_ready}, 32'h0);
      check("rst_rdata", pif.print_rdata, 32'h0);
      check("rst_char_valid", {31'h0, char_valid}, 32'h0);
      check("rst_char_data", {24'h0, char_data}, 32'h0);
      for (int i = 0; i < 12; i++) begin
         bus(tbl[i].ins, tbl[i].addr, tbl[i].wdata, tbl[i].wstrb, rd, lat, ae);
         check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp);
         check($sformatf("tbl%0d_lat", i), 32'(lat), 32'd1);
      end
      // single byte: ready after one cycle, char DIV cycles after the push
      log_ch.delete();
      log_t.delete();
      bus(1'b0, 32'h0, 32'h41, 4'h1, rd, lat, ae);
      check("t1_lat", 32'(lat), 32'd1);
      wait_chars(1);
      check("t1_char", {24'h0, log_ch[0]}, 32'h41);
      check("t1_delay", 32'(log_t[0] - ae), 32'(DIV));
      bus(1'b0, 32'h8, 32'h0, 4'h0, rd, lat, ae);
      check("t1_count", rd, 32'd1);
      // "Hi\n" back to back: order and exact spacing
      log_ch.delete();
      log_t.delete();
      msg = '{8'h48, 8'h69, 8'h0a};
      for (int i = 0; i < 3; i++) bus(1'b0, 32'h0, {24'h0, msg[i]}, 4'h1, rd, lat, ae);
      wait_chars(3);
      for (int i = 0; i < 3; i++) check($sformatf("t2_char%0d", i), {24'h0, log_ch[i]}, {24'h0, msg[i]});
      check("t2_gap0", 32'(log_t[1] - log_t[0]), 32'(DIV));
      check("t2_gap1", 32'(log_t[2] - log_t[1]), 32'(DIV));
      bus(1'b0, 32'h4, 32'h0, 4'h0, rd, lat, ae);
      check("t2_status", rd, 32'h1);
      // 17 pushes into a 16-deep FIFO: last one stalls until the first drain
      log_ch.delete();
      log_t.delete();
      ae17 = 0;
      lat17 = 0;
      for (int i = 0; i < 17; i++) begin
         bus(1'b0, 32'h0, (i == 16) ? 32'h0a : 32'(8'h61 + i), 4'h1, rd, lat, ae);
         if (i == 15) check("t3_lat16", 32'(lat), 32'd1);
         if (i == 16) begin
            lat17 = lat;
            ae17 = ae;
         end
      end
      check("t3_stall_lat", 32'(lat17), 32'(DIV - 2 * DEPTH + 2));
      wait_chars(17);
      check("t3_accept_after_drain", 32'(ae17), 32'(log_t[0] + 1));
      for (int i = 0; i < 17; i++)
         check($sformatf("t3_char%0d", i), {24'h0, log_ch[i]}, (i == 16) ? 32'h0a : 32'(8'h61 + i));
      // STATUS with three queued bytes; zero-strobe write is a read
      log_ch.delete();
      log_t.delete();
      msg = '{8'h78, 8'h79, 8'h0a};
      for (int i = 0; i < 3; i++) bus(1'b0, 32'h0, {24'h0, msg[i]}, 4'h1, rd, lat, ae);
      bus(1'b0, 32'h4, 32'h0, 4'h0, rd, lat, ae);
      check("t4_status3", rd, 32'h300);
      bus(1'b0, 32'h0, 32'h5a, 4'h0, rd, lat, ae);
      check("t4_zero_strobe_rdata", rd, 32'h0);
      bus(1'b0, 32'h4, 32'h0, 4'h0, rd, lat, ae);
      check("t4_status_after", rd, 32'h300);
      // instruction fetch to TXDATA has no side effect
      bus(1'b1, 32'h0, 32'h71, 4'h1, rd, lat, ae);
      check("t5_lat", 32'(lat), 32'd1);
      check("t5_rdata", rd, 32'h0);
      bus(1'b0, 32'h4, 32'h0, 4'h0, rd, lat, ae);
      check("t5_status", rd, 32'h300);
      wait_chars(3);
      bus(1'b0, 32'h8, 32'h0, 4'h0, rd, lat, ae);
      check("t5_count", rd, 32'd24);
      // reset with five bytes queued and a write in flight
      for (int i = 0; i < 5; i++) bus(1'b0, 32'h0, 32'h70, 4'h1, rd, lat, ae);
      base = log_ch.size();
      pif.print_valid = 1'b1;
      pif.print_instr = 1'b0;
      pif.print_addr = 32'h0;
      pif.print_wdata = 32'h72;
      pif.print_wstrb = 4'h1;
      rst = 1'b1;
      idle(2);
      pif.print_valid = 1'b0;
      rst = 1'b0;
      idle(3 * DIV);
      check("t6_no_chars", 32'(log_ch.size()), 32'(base));
      bus(1'b0, 32'h4, 32'h0, 4'h0, rd, lat, ae);
      check("t6_status", rd, 32'h1);
      bus(1'b0, 32'h8, 32'h0, 4'h0, rd, lat, ae);
      check("t6_count", rd, 32'h0);
      // random traffic, checked cycle by cycle against the model
      npush = 0;
      for (int n = 0; n < 150; n++) begin
         r = $urandom_range(0, 9);
         a = $urandom();
         d = $urandom();
         ins = 1'b0;
         s = 4'h1;
         if (r < 6) begin
            a[3:2] = 2'd0;
            npush++;
         end else if (r < 8) begin
            s = 4'h0;
            ins = 1'($urandom_range(0, 1));
         end else begin
            s = 4'($urandom_range(0, 15));
            ins = 1'($urandom_range(0, 1));
         end
         d[7:0] = (npush % 20 == 19) ? 8'h0a : 8'(8'h61 + $urandom_range(0, 25));
         bus(ins, a, d, s, rd, lat, ae);
         idle($urandom_range(0, 3));
         if (n % 40 == 39) idle(12 * DIV);
      end
      bus(1'b0, 32'h0, 32'h0a, 4'h1, rd, lat, ae);
      for (int k = 0; k < 5000 && mq.size() != 0; k++) @(posedge clk);
      idle(2);
      bus(1'b0, 32'h8, 32'h0, 4'h0, rd, lat, ae);
      check("rand_count", rd, m_cnt);
      bus(1'b0, 32'h4, 32'h0, 4'h0, rd, lat, ae);
      check("rand_status_empty", rd, 32'h1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
